// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - unified memory port sequencer/arbiter between the
// multicycle control unit and a DMA/debug requester, with timeout and anti-starvation.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_error
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int WAIT_W   = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_CPU = 2'd1,
    GRANT_DMA = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [STARVE_W-1:0] starve_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                starved;
  logic                pick_cpu;
  logic                pick_dma;
  logic                start;
  logic                timed_out;
  logic                finish;
  logic [DATA_W-1:0]   rd_result;

  // DMA only wins a contested slot once the CPU has taken STARVE_MAX of them in a row.
  always_comb begin
    starved   = (starve_cnt == STARVE_W'(STARVE_MAX));
    pick_dma  = dma_req & (~cpu_req | starved);
    pick_cpu  = cpu_req & ~pick_dma;
    start     = (state == IDLE) & (pick_cpu | pick_dma);
    timed_out = ~mem_ready & (wait_cnt == WAIT_W'(TIMEOUT - 1));
    finish    = (state != IDLE) & (mem_ready | timed_out);
    rd_result = mem_ready ? mem_rdata : {DATA_W{1'b1}};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_cpu) begin
          state_nxt = GRANT_CPU;
        end else if (pick_dma) begin
          state_nxt = GRANT_DMA;
        end
      end
      GRANT_CPU, GRANT_DMA: begin
        if (finish) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      cpu_done   <= 1'b0;
      dma_done   <= 1'b0;
      bus_error  <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      bus_error <= 1'b0;
      if (start) begin
        mem_en    <= 1'b1;
        mem_we    <= pick_dma ? dma_we    : cpu_we;
        mem_addr  <= pick_dma ? dma_addr  : cpu_addr;
        mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
        wait_cnt  <= '0;
        if (pick_dma) begin
          starve_cnt <= '0;
        end else if (dma_req && !starved) begin
          starve_cnt <= starve_cnt + STARVE_W'(1);
        end
      end else if (finish) begin
        // Latched mem_we tells us whether this access returns data.
        mem_en    <= 1'b0;
        bus_error <= timed_out;
        if (state == GRANT_CPU) begin
          cpu_done <= 1'b1;
          if (!mem_we) begin
            cpu_rdata <= rd_result;
          end
        end else begin
          dma_done <= 1'b1;
          if (!mem_we) begin
            dma_rdata <= rd_result;
          end
        end
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter with a
// transaction-level reference model and per-cycle output comparison.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_done, cpu_stall, dma_done, mem_en, mem_we, mem_ready, bus_error;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding access, owner 1=cpu 2=dma, elapsed = cycles since grant.
  int          m_owner, m_elapsed, m_starve;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_data;
  logic        e_cpu_done, e_dma_done, e_berr;
  logic [31:0] e_cpu_rdata, e_dma_rdata;
  logic        m_abort;
  int          grants[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_elapsed = 0; m_starve = 0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0;
      e_cpu_done = 1'b0; e_dma_done = 1'b0; e_berr = 1'b0;
      e_cpu_rdata = '0; e_dma_rdata = '0;
    end else begin
      e_cpu_done = 1'b0; e_dma_done = 1'b0; e_berr = 1'b0;
      if (m_owner == 0) begin
        if (cpu_req || dma_req) begin
          if (dma_req && (!cpu_req || m_starve == STARVE_MAX)) begin
            m_owner = 2; m_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata;
            m_starve = 0;
          end else begin
            m_owner = 1; m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
            if (dma_req && m_starve < STARVE_MAX) m_starve++;
          end
          grants.push_back(m_owner);
          m_elapsed = 0;
        end
      end else begin
        m_abort = !mem_ready && (m_elapsed + 1 == TIMEOUT);
        if (mem_ready || m_abort) begin
          m_data = mem_ready ? mem_rdata : 32'hFFFF_FFFF;
          if (m_owner == 1) begin
            e_cpu_done = 1'b1;
            if (!m_we) e_cpu_rdata = m_data;
          end else begin
            e_dma_done = 1'b1;
            if (!m_we) e_dma_rdata = m_data;
          end
          e_berr  = m_abort;
          m_owner = 0;
        end else begin
          m_elapsed++;
        end
      end
    end
  end

  // Memory responder: ready after `lat` cycles of an outstanding access.
  int          lat = 0;
  logic [31:0] rd_val = '0;
  always @(negedge clk) begin
    mem_ready = (m_owner != 0) && (m_elapsed >= lat);
    mem_rdata = rd_val;
  end

  always @(posedge clk) cyc <= cyc + 1;

  int en_cnt = 0, stall_cnt = 0, cpu_done_n = 0, dma_done_n = 0;
  int cpu_done_cyc = 0, dma_done_cyc = 0, berr_cyc = -1;

  always @(posedge clk) begin
    #1;
    chk("mem_en",    mem_en,    m_owner != 0);
    chk("mem_we",    mem_we,    m_we);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("cpu_done",  cpu_done,  e_cpu_done);
    chk("dma_done",  dma_done,  e_dma_done);
    chk("bus_error", bus_error, e_berr);
    chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
    chk("dma_rdata", dma_rdata, e_dma_rdata);
    if (mem_en) en_cnt++;
    if (cpu_done) begin cpu_done_n++; cpu_done_cyc = cyc; end
    if (dma_done) begin dma_done_n++; dma_done_cyc = cyc; end
    if (bus_error) berr_cyc = cyc;
  end

  always @(negedge clk) begin
    #1;
    chk("cpu_stall", cpu_stall, cpu_req & ~e_cpu_done);
    if (cpu_stall) stall_cnt++;
  end

  task automatic wait_done(input int who);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if ((who == 1 && e_cpu_done) || (who == 2 && e_dma_done)) break;
      t++;
      if (t > 200) begin
        chk("wait_done_bound", 0, 1);
        break;
      end
    end
  endtask

  task automatic run_both(input int n);
    int got, t;
    got = 0;
    t = 0;
    cpu_req = 1'b1;
    dma_req = 1'b1;
    while (got < n && t < 500) begin
      @(negedge clk);
      if (e_cpu_done || e_dma_done) got++;
      t++;
    end
    if (got < n) chk("run_both_bound", got, n);
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  int req_cyc;
  int seq12[12] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1, 1};
  int seq5[5]   = '{1, 1, 1, 1, 2};

  initial begin
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_cpu_rdata", cpu_rdata, 0);
    chk("reset_done", {cpu_done, dma_done, bus_error}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait CPU read
    rd_val = 32'hDEAD_BEEF; lat = 0; en_cnt = 0; stall_cnt = 0;
    cpu_addr = 32'h10; cpu_we = 0; cpu_req = 1; req_cyc = cyc;
    wait_done(1);
    cpu_req = 0;
    @(negedge clk); #2;
    chk("t1_en_cycles", en_cnt, 1);
    chk("t1_latency", cpu_done_cyc - req_cyc, 2);
    chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_stall_cycles", stall_cnt, 2);

    // DMA write with 3 wait cycles
    rd_val = 32'hCAFE_F00D; lat = 3; en_cnt = 0;
    dma_addr = 32'h20; dma_wdata = 32'h1234_5678; dma_we = 1; dma_req = 1; req_cyc = cyc;
    wait_done(2);
    dma_req = 0;
    @(negedge clk); #2;
    chk("t2_en_cycles", en_cnt, 4);
    chk("t2_latency", dma_done_cyc - req_cyc, 5);
    chk("t2_rdata_kept", dma_rdata, 0);
    chk("t2_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("t2_mem_we", mem_we, 1);

    // Continuous contention
    grants.delete(); lat = 0; rd_val = 32'h55AA_55AA;
    cpu_addr = 32'h100; dma_addr = 32'h200; dma_we = 0;
    cpu_done_n = 0; dma_done_n = 0;
    run_both(12);
    @(negedge clk); #2;
    for (int i = 0; i < 12; i++) chk($sformatf("t3_grant%0d", i), grants[i], seq12[i]);
    chk("t3_model_starve", m_starve, 2);
    chk("t3_cpu_dones", cpu_done_n, 10);
    chk("t3_dma_dones", dma_done_n, 2);

    // Timeout on a CPU read
    lat = 1000; en_cnt = 0; berr_cyc = -1;
    cpu_addr = 32'h300; cpu_req = 1; req_cyc = cyc;
    wait_done(1);
    cpu_req = 0;
    @(negedge clk); #2;
    chk("t4_en_cycles", en_cnt, TIMEOUT);
    chk("t4_latency", cpu_done_cyc - req_cyc, TIMEOUT + 1);
    chk("t4_berr_with_done", berr_cyc, cpu_done_cyc);
    chk("t4_rdata", cpu_rdata, 32'hFFFF_FFFF);
    chk("t4_idle", mem_en, 0);

    // Reset while idle clears the starvation count
    lat = 0;
    run_both(2);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    grants.delete();
    run_both(1);
    @(negedge clk); #2;
    chk("t5a_first_grant", grants[0], 1);

    // Reset in the 2nd wait cycle of a DMA read
    lat = 1000; dma_done_n = 0;
    dma_addr = 32'h400; dma_we = 0; dma_req = 1;
    repeat (3) @(negedge clk);
    #2;
    chk("t5_mem_en_before", mem_en, 1);
    rst_n = 1'b0;
    dma_req = 0;
    #1;
    chk("t5_mem_en_now", mem_en, 0);
    chk("t5_mem_addr_now", mem_addr, 0);
    chk("t5_rdata_now", {cpu_rdata, dma_rdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_dma_done", dma_done_n, 0);
    grants.delete(); lat = 1;
    cpu_addr = 32'h500; dma_addr = 32'h600;
    run_both(5);
    @(negedge clk); #2;
    for (int i = 0; i < 5; i++) chk($sformatf("t5_grant%0d", i), grants[i], seq5[i]);

    // Address change mid-access is ignored
    lat = 2; en_cnt = 0;
    cpu_addr = 32'h40; cpu_we = 0; cpu_req = 1;
    @(negedge clk);
    cpu_addr = 32'h80;
    wait_done(1);
    #2;
    chk("t6_mem_addr_held", mem_addr, 32'h40);
    cpu_req = 0;
    @(negedge clk); #2;
    chk("t6_en_cycles", en_cnt, 3);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single unified memory port of the multicycle datapath. It shares the memory between the multicycle control unit (instruction fetch and load/store, driven by MemRead/MemWrite/IorD) and a secondary requester (DMA/debug loader). It handles variable-latency memory through a ready handshake, and stalls the control unit until its access completes. A timeout aborts hung accesses, and an anti-starvation counter bounds DMA wait time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive contested CPU grants before DMA is forced to win (≥1)
- TIMEOUT, 16, wait cycles for mem_ready before abort (≥2)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request (MemRead|MemWrite), level, held until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address (PC or ALUOut per IorD, muxed upstream)
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  registered read data, valid when cpu_done=1
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  combinational: cpu_req & ~cpu_done; control unit holds state while high
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  same semantics as CPU side
- dma_rdata  out  DATA_W;  dma_done  out  1  same semantics as CPU side
- mem_en  out  1  access strobe, held until mem_ready sampled
- mem_we  out  1;  mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W  registered, stable while mem_en=1
- mem_rdata  in  DATA_W;  mem_ready  in  1  memory completes the access on a cycle with mem_en & mem_ready
- bus_error  out  1  one-cycle pulse coincident with done of a timed-out access

## Operation
- States: IDLE, GRANT_CPU, GRANT_DMA.
- IDLE: on an edge where either request is high, go to GRANT_x. At that same edge, latch the winner's we/addr/wdata into the mem_* registers, set mem_en=1, and clear the wait counter.
- Arbitration when both requests are high: CPU wins unless starve_cnt == STARVE_MAX, in which case DMA wins.
- starve_cnt increments on every CPU grant made while dma_req=1. It is cleared on every DMA grant and saturates at STARVE_MAX. Uncontested CPU grants leave it unchanged.
- GRANT_x, mem_ready=1 sampled: go to IDLE with mem_en=0. Pulse x_done=1 for one cycle. For reads, load x_rdata from mem_rdata. For writes, x_rdata keeps its previous value.
- GRANT_x, mem_ready=0: wait counter increments each cycle.
  - When the counter reaches TIMEOUT-1 with mem_ready still 0, go to IDLE with mem_en=0.
  - Pulse x_done=1 and bus_error=1, and load x_rdata with all ones (reads only).
- Grant owner and latched mem_* values are frozen during an access. Request/address changes from either side are ignored until IDLE.
- Requesters drop req in the cycle they see done, unless they want a new access. A req still high in the done cycle is sampled in IDLE as a new request.
- Reset asserted (low), including mid-access:
  - Immediately state=IDLE; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rdata=0, dma_rdata=0, cpu_done=0, dma_done=0, bus_error=0.
  - starve_cnt=0, wait counter=0; cpu_stall follows cpu_req.
  - No done pulse is issued for the aborted access.

## Timing
- Zero-wait memory (mem_ready=1 whenever mem_en=1): req high before edge N → mem_en high cycle N..N+1 → done high cycle N+1..N+2 → next grant no earlier than edge N+2. Latency 2 cycles, throughput one access per 2 cycles per requester.
- Each memory wait cycle adds one cycle of latency. The timeout abort occurs TIMEOUT cycles after the grant edge.
- mem_en is high for exactly 1 + (wait cycles) cycles per access.
- done and bus_error are never high for two consecutive cycles. cpu_done and dma_done are never high together.
- Worst-case DMA latency under continuous CPU load: STARVE_MAX CPU accesses, then the DMA grant.

## Test plan
- Single CPU read, zero-wait, addr=0x00000010, mem_rdata=0xDEADBEEF → mem_en high for 1 cycle; cpu_done and cpu_rdata=0xDEADBEEF 2 cycles after req; cpu_stall high for exactly 2 cycles.
- DMA write addr=0x20, wdata=0x12345678, mem_ready delayed 3 cycles → mem_we=1, mem_wdata stable for 4 cycles; dma_done 5 cycles after req; dma_rdata unchanged.
- cpu_req and dma_req held continuously, STARVE_MAX=4 → grant sequence CPU,CPU,CPU,CPU,DMA,CPU,…; starve_cnt returns to 0 after the DMA grant.
- CPU read with mem_ready tied 0, TIMEOUT=16 → mem_en high for 16 cycles; cpu_done and bus_error pulse together; cpu_rdata=0xFFFFFFFF; returns to IDLE.
- Reset pulled low in the 2nd wait cycle of a DMA read → mem_en and all outputs go to 0 immediately; no dma_done; after release, a CPU request is granted normally with starve_cnt=0.
- Change cpu_addr from 0x40 to 0x80 mid-access with 2 wait cycles → mem_addr stays 0x40 until done.
